// File: rtl/branch_resolve_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolve_pkg
//   Shared types and constants for the execute-stage branch resolution unit:
//   FSM state encoding, the 2-bit predictor counter type and its reset value,
//   the sequential-PC increment, and small update helpers.
// ----------------------------------------------------------------------------
package branch_resolve_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } br_state_e;

    // 2-bit saturating predictor counter; bit 1 is the taken prediction.
    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken.
    localparam bht_ctr_t BHT_CTR_RST = 2'b01;

    // Fall-through distance for a not-taken branch.
    localparam int unsigned PC_INC = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic bht_ctr_t ctr_update(input bht_ctr_t c, input logic taken);
        bht_ctr_t r;
        r = c;
        if (taken && (c != 2'b11)) r = c + 2'b01;
        if (!taken && (c != 2'b00)) r = c - 2'b01;
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_bht.sv
// ----------------------------------------------------------------------------
// bht
//   Table of 2^BHT_IDX_W two-bit saturating counters indexed by
//   pc[BHT_IDX_W+1:2].
//   Ports:
//     clk, rst       clock, synchronous active-high reset (all entries -> 01)
//     rd_pc          lookup PC; rd_taken is bit 1 of its entry (combinational)
//     upd_en         update strobe
//     upd_pc         PC of the entry to update
//     upd_taken      resolved direction: increment if 1, decrement if 0
// ----------------------------------------------------------------------------
module bht
    import branch_resolve_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BHT_IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_taken,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int ENTRIES = 1 << BHT_IDX_W;

    bht_ctr_t tbl_q [ENTRIES];
    bht_ctr_t tbl_d [ENTRIES];

    logic [BHT_IDX_W-1:0] rd_idx;
    logic [BHT_IDX_W-1:0] upd_idx;

    // Only the index bits of the PCs select an entry; the rest are don't-care.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc, upd_pc};

    assign rd_idx   = rd_pc[BHT_IDX_W+1:2];
    assign upd_idx  = upd_pc[BHT_IDX_W+1:2];
    assign rd_taken = tbl_q[rd_idx][1];

    always_comb begin
        tbl_d = tbl_q;
        if (upd_en) tbl_d[upd_idx] = ctr_update(tbl_q[upd_idx], upd_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= BHT_CTR_RST;
        end else begin
            tbl_q <= tbl_d;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
//   Execute-stage branch resolution. Compares the ALU branch outcome with the
//   prediction carried from fetch; on a mispredict it issues a PC redirect
//   over a valid/ready handshake, then holds flush/stall_ex for FLUSH_CYCLES
//   after the handshake so wrong-path instructions drain from IF/ID.
//   Keeps saturating resolved-branch and mispredict counters.
//
//   Build option: define BRANCH_PRED_EN to build the 2-bit counter predictor
//   (bht). Without it, prediction is static not-taken (if_pred_taken = 0) and
//   a mispredict is any taken branch.
//
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     ex_valid, ex_is_branch     valid conditional branch in EX
//     ex_taken, ex_pred_taken    actual / predicted direction
//     ex_pc, ex_target           branch PC and computed target
//     if_pc, if_pred_taken       fetch-side predictor lookup (combinational)
//     redirect_valid/ready/pc    corrected-PC handshake to fetch
//     flush, stall_ex            squash IF/ID, hold EX
//     br_count, mp_count         saturating performance counters
// ----------------------------------------------------------------------------
module branch_resolve #(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_IDX_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] ex_target,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic            stall_ex,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    import branch_resolve_pkg::*;

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    br_state_e       state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            flush_q, flush_d;
    logic            stall_ex_q, stall_ex_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [31:0]     br_count_q, br_count_d;
    logic [31:0]     mp_count_q, mp_count_d;

    logic            resolve;
    logic            mispredict;
    logic [PC_W-1:0] corr_pc;

    // Branches seen outside IDLE are wrong-path and must not train anything.
    assign resolve = ex_valid && ex_is_branch && (state_q == ST_IDLE);

`ifdef BRANCH_PRED_EN
    assign mispredict = ex_taken != ex_pred_taken;

    bht #(
        .PC_W      (PC_W),
        .BHT_IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (if_pc),
        .rd_taken  (if_pred_taken),
        .upd_en    (resolve),
        .upd_pc    (ex_pc),
        .upd_taken (ex_taken)
    );
`else
    // Static not-taken: fetch always falls through, so only taken branches
    // can have gone down the wrong path.
    assign mispredict    = ex_taken;
    assign if_pred_taken = 1'b0;

    logic [BHT_IDX_W+1:0] unused_if_idx;
    logic                 unused_pred_inputs;
    assign unused_if_idx      = if_pc[BHT_IDX_W+1:0];
    assign unused_pred_inputs = ^{ex_pred_taken, if_pc};
`endif

    // Sequential PC wraps modulo 2^PC_W.
    assign corr_pc = ex_taken ? ex_target : (ex_pc + PC_W'(PC_INC));

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        flush_d          = flush_q;
        stall_ex_d       = stall_ex_q;
        redirect_pc_d    = redirect_pc_q;
        drain_cnt_d      = drain_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (resolve && mispredict) begin
                    state_d          = ST_REDIRECT;
                    redirect_valid_d = 1'b1;
                    flush_d          = 1'b1;
                    stall_ex_d       = 1'b1;
                    redirect_pc_d    = corr_pc;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d          = ST_DRAIN;
                    redirect_valid_d = 1'b0;
                    drain_cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                // Counter runs FLUSH_CYCLES-1 .. 0, one cycle per value.
                if (drain_cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    flush_d    = 1'b0;
                    stall_ex_d = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
                stall_ex_d       = 1'b0;
            end
        endcase

        br_count_d = resolve ? sat_inc32(br_count_q) : br_count_q;
        mp_count_d = (resolve && mispredict) ? sat_inc32(mp_count_q) : mp_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            stall_ex_q       <= 1'b0;
            redirect_pc_q    <= '0;
            drain_cnt_q      <= '0;
            br_count_q       <= '0;
            mp_count_q       <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            stall_ex_q       <= stall_ex_d;
            redirect_pc_q    <= redirect_pc_d;
            drain_cnt_q      <= drain_cnt_d;
            br_count_q       <= br_count_d;
            mp_count_q       <= mp_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign flush          = flush_q;
    assign stall_ex       = stall_ex_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign mp_count       = mp_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve
//   Directed stimulus for branch_resolve (PC_W=32, FLUSH_CYCLES=2). Expected
//   redirect PCs are queued when a mispredict is issued; a monitor pops and
//   compares on every completed redirect handshake. Timing, counter and
//   flush-length checks are made inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, if_pc;
    logic        if_pred_taken;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush, stall_ex;
    logic [31:0] br_count, mp_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    branch_resolve #(
        .PC_W         (32),
        .FLUSH_CYCLES (2),
        .BHT_IDX_W    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stall_ex       (stall_ex),
        .br_count       (br_count),
        .mp_count       (mp_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one expected PC per completed handshake.
    always @(negedge clk) begin
        if (!rst && redirect_valid && redirect_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_redirect: got pc 0x%0h expected no redirect", redirect_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_redirect_pc", redirect_pc, mon_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one branch in EX for a single cycle; returns in cycle N+1.
    task automatic issue(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic pr);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_taken      = tk;
        ex_pred_taken = pr;
        step();
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
    endtask

    // Count cycles with flush (and redirect_valid) high from now until flush
    // drops; returns in the first cycle with flush low.
    task automatic measure(output int fl, output int rv);
        fl = 0;
        rv = 0;
        for (int i = 0; i < 40; i++) begin
            if (!flush) return;
            fl++;
            if (redirect_valid) rv++;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL flush_timeout: got flush still high after 40 cycles expected deassert");
    endtask

    int fl, rv;

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = '0; ex_target = '0; if_pc = '0; redirect_ready = 0;
        step();
        step();
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 0);
        chk("rst_flush",          {31'd0, flush}, 0);
        chk("rst_stall_ex",       {31'd0, stall_ex}, 0);
        chk("rst_redirect_pc",    redirect_pc, 0);
        chk("rst_br_count",       br_count, 0);
        chk("rst_mp_count",       mp_count, 0);
        chk("rst_if_pred",        {31'd0, if_pred_taken}, 0);
        rst = 1'b0;
        step();

        // Correct not-taken prediction: counted, no redirect.
        issue(32'h100, 32'h180, 1'b0, 1'b0);
        chk("np_redirect_valid", {31'd0, redirect_valid}, 0);
        chk("np_flush",          {31'd0, flush}, 0);
        chk("np_br_count",       br_count, 1);
        chk("np_mp_count",       mp_count, 0);

        // Taken mispredict, fetch ready immediately.
        redirect_ready = 1'b1;
        exp_q.push_back(32'h200);
        issue(32'h100, 32'h200, 1'b1, 1'b0);
        chk("mp_redirect_valid", {31'd0, redirect_valid}, 1);
        chk("mp_redirect_pc",    redirect_pc, 32'h200);
        chk("mp_stall_ex",       {31'd0, stall_ex}, 1);
        chk("mp_br_count",       br_count, 2);
        chk("mp_mp_count",       mp_count, 1);
        measure(fl, rv);
        chk("mp_flush_cycles",   fl, 3);
        chk("mp_valid_cycles",   rv, 1);
        chk("mp_stall_released", {31'd0, stall_ex}, 0);

        // Back-to-back: mispredict in the first IDLE cycle after drain.
        exp_q.push_back(32'h80);
        issue(32'h300, 32'h80, 1'b1, 1'b0);
        chk("b2b_redirect_valid", {31'd0, redirect_valid}, 1);
        chk("b2b_redirect_pc",    redirect_pc, 32'h80);
        chk("b2b_br_count",       br_count, 3);
        chk("b2b_mp_count",       mp_count, 2);
        measure(fl, rv);
        chk("b2b_flush_cycles",   fl, 3);

        // Backpressure for 5 cycles; a wrong-path branch arrives meanwhile.
        redirect_ready = 1'b0;
        exp_q.push_back(32'h600);
        issue(32'h500, 32'h600, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_redirect_valid", {31'd0, redirect_valid}, 1);
            chk("bp_redirect_pc",    redirect_pc, 32'h600);
            chk("bp_flush",          {31'd0, flush}, 1);
            if (i == 1) begin
                ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1;
                ex_pred_taken = 1'b0; ex_pc = 32'h700; ex_target = 32'h720;
            end
            if (i == 3) begin
                ex_valid = 1'b0; ex_is_branch = 1'b0;
            end
            step();
        end
        chk("bp_br_count", br_count, 4);
        chk("bp_mp_count", mp_count, 3);
        redirect_ready = 1'b1;
        measure(fl, rv);
        chk("bp_flush_cycles", fl, 3);
        chk("bp_valid_cycles", rv, 1);

        // Reset while a redirect is pending: it is dropped.
        redirect_ready = 1'b0;
        issue(32'h800, 32'h900, 1'b1, 1'b0);
        chk("mr_redirect_valid_pre", {31'd0, redirect_valid}, 1);
        rst = 1'b1;
        step();
        chk("mr_redirect_valid", {31'd0, redirect_valid}, 0);
        chk("mr_flush",          {31'd0, flush}, 0);
        chk("mr_stall_ex",       {31'd0, stall_ex}, 0);
        chk("mr_redirect_pc",    redirect_pc, 0);
        chk("mr_br_count",       br_count, 0);
        chk("mr_mp_count",       mp_count, 0);
        rst = 1'b0;
        redirect_ready = 1'b1;
        step();
        // Back in IDLE: a fresh mispredict is accepted.
        exp_q.push_back(32'h44);
        issue(32'h10, 32'h44, 1'b1, 1'b0);
        chk("mr_idle_redirect", {31'd0, redirect_valid}, 1);
        chk("mr_idle_br_count", br_count, 1);
        measure(fl, rv);
        chk("mr_flush_cycles", fl, 3);

`ifdef BRANCH_PRED_EN
        // Training at 0x40 with correct predictions (no redirects).
        if_pc = 32'h40;
        #1;
        chk("bht_init", {31'd0, if_pred_taken}, 0);
        issue(32'h40, 32'h60, 1'b1, 1'b1);
        issue(32'h40, 32'h60, 1'b1, 1'b1);
        chk("bht_trained", {31'd0, if_pred_taken}, 1);
        issue(32'h40, 32'h60, 1'b1, 1'b1);
        issue(32'h40, 32'h60, 1'b1, 1'b1);
        chk("bht_sat_hi", {31'd0, if_pred_taken}, 1);
        issue(32'h40, 32'h60, 1'b0, 1'b0);
        chk("bht_sat_dec1", {31'd0, if_pred_taken}, 1);
        issue(32'h40, 32'h60, 1'b0, 1'b0);
        chk("bht_sat_dec2", {31'd0, if_pred_taken}, 0);
        chk("bht_no_redirect", {31'd0, redirect_valid}, 0);

        // Not-taken mispredict at the top of the address space wraps to 0.
        exp_q.push_back(32'h0);
        issue(32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        measure(fl, rv);
`endif

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit. It consumes the ALU's taken flag for each branch in EX and decides whether fetch went down the wrong path. On a mispredict it drives a PC redirect to fetch over a valid/ready handshake and holds a flush to IF/ID until the wrong-path instructions have drained. It sits between the execute stage and fetch, and keeps branch/mispredict performance counters.

## Interface
- `PC_W`, default 32: PC and target width.
- `FLUSH_CYCLES`, default 2: drain cycles after the redirect is accepted; must be ≥ 1.
- `BHT_IDX_W`, default 4: predictor index width, giving 2^BHT_IDX_W entries. Used only with `BRANCH_PRED_EN`.
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_is_branch` in 1: the EX instruction is a conditional branch.
- `ex_taken` in 1: ALU branch flag (beq/bne/bgt/blt outcome).
- `ex_pred_taken` in 1: prediction carried down the pipe from fetch.
- `ex_pc` in PC_W: PC of the EX instruction.
- `ex_target` in PC_W: computed branch target.
- `if_pc` in PC_W: fetch PC, used for the predictor lookup.
- `if_pred_taken` out 1: combinational prediction for `if_pc`.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_ready` in 1: fetch accepts the redirect.
- `redirect_pc` out PC_W: corrected PC.
- `flush` out 1: squash IF/ID.
- `stall_ex` out 1: hold EX while a redirect is pending.
- `br_count` out 32: resolved branches, saturating.
- `mp_count` out 32: mispredicts, saturating.

## Operation
- Resolution event: `ex_valid & ex_is_branch` while in IDLE.
- Mispredict: `ex_taken != ex_pred_taken`.
- Corrected PC: `ex_target` if taken, else `ex_pc + 4` (modulo 2^PC_W, wraps silently).
- FSM states:
  - IDLE: on a mispredict, latch `redirect_pc` and go to REDIRECT. A correct prediction stays in IDLE.
  - REDIRECT: `redirect_valid=1`, `flush=1`, `stall_ex=1`. `redirect_pc` holds stable. When `redirect_ready=1`, load the drain counter with FLUSH_CYCLES-1 and go to DRAIN.
  - DRAIN: `flush=1`, `stall_ex=1`, `redirect_valid=0`. Decrement the counter each cycle; at 0 go to IDLE.
- Branches presented in EX outside IDLE are wrong-path. They are ignored: no counter update, no predictor update.
- `br_count` increments on every resolution event. `mp_count` increments on every mispredict. Both saturate at 0xFFFFFFFF.
- Reset values: state IDLE, `redirect_valid=0`, `flush=0`, `stall_ex=0`, `redirect_pc=0`, both counters 0, all predictor entries 2'b01.
- `rst` asserted in any state returns the block to the reset values at the next edge. A redirect in flight is dropped.

## Timing
- Mispredict resolved in cycle N → `redirect_valid`, `flush` and `stall_ex` all go high in cycle N+1. All outputs except `if_pred_taken` are registered.
- The handshake completes in the first cycle with `redirect_valid & redirect_ready`. If `redirect_ready` is already high in N+1, `redirect_valid` is high for exactly one cycle.
- After the handshake cycle, `flush` stays high for exactly FLUSH_CYCLES more cycles. It deasserts together with `stall_ex`.
- Back-to-back: a mispredict may be accepted in the first IDLE cycle after DRAIN ends.
- Counter and predictor updates become visible at cycle N+1.

## Configuration
- Macro `BRANCH_PRED_EN`.
- Defined:
  - 2^BHT_IDX_W-entry table of 2-bit saturating counters, indexed by `pc[BHT_IDX_W+1:2]`.
  - `if_pred_taken` is bit 1 of the entry addressed by `if_pc`.
  - On every resolution event, the entry addressed by `ex_pc` is incremented if taken and decremented if not, saturating at 00/11.
- Not defined:
  - No table is built.
  - `if_pred_taken` is tied to 0 (static not-taken), so a mispredict is simply `ex_taken`.

## Structure
- Shared package holds:
  - The FSM state enum (IDLE, REDIRECT, DRAIN).
  - The predictor counter typedef (2-bit) and its reset constant 2'b01.
  - The increment constant 4 used for `ex_pc + 4`.
- One sub-module, `bht`: the counter table with a combinational read port and a synchronous update port. It is instantiated only under `BRANCH_PRED_EN`.

## Test plan
- Correct prediction, not-taken: `ex_taken=0`, `ex_pred_taken=0`, `ex_pc=0x100` → no redirect, `br_count=1`, `mp_count=0`.
- Mispredict, taken, with `redirect_ready=1`:
  - Stimulus: `ex_pc=0x100`, `ex_target=0x200`, `ex_taken=1`.
  - Response: N+1 `redirect_valid=1`, `redirect_pc=0x200`; `flush` high for 1+2 cycles; `mp_count=1`.
- Mispredict, not-taken (predictor build): `ex_pred_taken=1`, `ex_taken=0`, `ex_pc=0xFFFFFFFC` → `redirect_pc=0x00000000` (wrap).
- Backpressure:
  - Stimulus: `redirect_ready` held low for 5 cycles.
  - Response: `redirect_valid`, `redirect_pc` and `flush` stable for 5 cycles. A branch presented in EX during those cycles leaves `br_count` unchanged.
- Reset mid-operation: `rst=1` in REDIRECT → next cycle all outputs 0, state IDLE, counters 0.
- Predictor training (`BRANCH_PRED_EN`): branch at 0x40 taken twice → `if_pred_taken=1` for `if_pc=0x40`. Counter saturates at 11 after further taken resolutions.
